// File: rtl/physics_pkg.sv
// Shared widths, integrator FSM state type and signed saturation helper for the soft-body physics stages.
package physics_pkg;

    localparam int POSITION_SIZE_DEF = 8;
    localparam int VELOCITY_SIZE_DEF = 8;
    localparam int FORCE_SIZE_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } integ_state_t;

    // Two guard bits keep any add of the three operand kinds free of overflow before saturation.
    function automatic int sum_width(input int pos_w, input int vel_w, input int frc_w);
        int m;
        m = pos_w;
        if (vel_w > m) m = vel_w;
        if (frc_w > m) m = frc_w;
        return m + 2;
    endfunction

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
    endfunction

endpackage

// File: rtl/node_integrator_sat_add.sv
// sat_add: signed a+b formed at SUM_W bits, saturated to OUT_W, with an optional symmetric clamp.
module sat_add
    import physics_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int B_W       = 8,
    parameter int OUT_W     = 8,
    parameter int SUM_W     = 10,
    parameter bit CLAMP_EN  = 1'b0,
    parameter int CLAMP_MAX = 0
) (
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [OUT_W-1:0] y_o
);

    logic signed [SUM_W-1:0] sum;
    logic signed [31:0]      sat;
    logic signed [31:0]      lim;

    // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        sum = SUM_W'(a_i) + SUM_W'(b_i);
        sat = sat_signed(32'(sum), OUT_W);
        lim = sat;
        if (CLAMP_EN) begin
            if (sat > CLAMP_MAX)       lim = CLAMP_MAX;
            else if (sat < -CLAMP_MAX) lim = -CLAMP_MAX;
        end
        y_o = OUT_W'(lim);
    end

endmodule

// File: rtl/node_integrator.sv
// Explicit-Euler soft-body integrator: one force beat per node updates velocity then position.
// Optional velocity clamp to +/-VMAX is enabled by defining NODE_INTEGRATOR_VCLAMP_EN.
module node_integrator
    import physics_pkg::*;
#(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = POSITION_SIZE_DEF,
    parameter int VELOCITY_SIZE = VELOCITY_SIZE_DEF,
    parameter int FORCE_SIZE    = FORCE_SIZE_DEF,
    parameter int DT_SHIFT      = 2,
    parameter int POS_SHIFT     = 0,
    parameter int GRAVITY       = -4,
    parameter int VMAX          = 100
) (
    input  logic                                              clk_in,
    input  logic                                              rst_in,
    input  logic                                              init_valid,
    input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]      init_nodes,
    input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]      init_velocities,
    input  logic                                              step_start,
    input  logic signed [FORCE_SIZE-1:0]                      force_x_in,
    input  logic signed [FORCE_SIZE-1:0]                      force_y_in,
    input  logic                                              force_valid_in,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]      nodes_out,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]      velocities_out,
    output logic                                              busy_out,
    output logic                                              output_valid,
    output logic                                              err_out
);

    localparam int SUM_W = sum_width(POSITION_SIZE, VELOCITY_SIZE, FORCE_SIZE);
    localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic signed [SUM_W-1:0] GRAV_EXT = SUM_W'(GRAVITY);
`ifdef NODE_INTEGRATOR_VCLAMP_EN
    localparam bit VCLAMP_EN = 1'b1;
`else
    localparam bit VCLAMP_EN = 1'b0;
`endif

    integ_state_t                                   state_q;
    logic [IDX_W-1:0]                               idx_q;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   pos_q;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   vel_q;
    logic                                           valid_q;
    logic                                           busy_q;
    logic                                           err_q;

    logic signed [SUM_W-1:0]         dvx, dvy;
    logic signed [VELOCITY_SIZE-1:0] vx_cur, vy_cur, vx_d, vy_d, dpx, dpy;
    logic signed [POSITION_SIZE-1:0] px_cur, py_cur, px_d, py_d;

    assign vx_cur = vel_q[0][idx_q];
    assign vy_cur = vel_q[1][idx_q];
    assign px_cur = pos_q[0][idx_q];
    assign py_cur = pos_q[1][idx_q];
    assign dvx    = SUM_W'(force_x_in) >>> DT_SHIFT;
    assign dvy    = (SUM_W'(force_y_in) + GRAV_EXT) >>> DT_SHIFT;
    // Position integrates the already saturated (and clamped) velocity that is about to be stored.
    assign dpx    = vx_d >>> POS_SHIFT;
    assign dpy    = vy_d >>> POS_SHIFT;

    sat_add #(.A_W(VELOCITY_SIZE), .B_W(SUM_W), .OUT_W(VELOCITY_SIZE), .SUM_W(SUM_W),
              .CLAMP_EN(VCLAMP_EN), .CLAMP_MAX(VMAX))
        u_vel_x (.a_i(vx_cur), .b_i(dvx), .y_o(vx_d));
    sat_add #(.A_W(VELOCITY_SIZE), .B_W(SUM_W), .OUT_W(VELOCITY_SIZE), .SUM_W(SUM_W),
              .CLAMP_EN(VCLAMP_EN), .CLAMP_MAX(VMAX))
        u_vel_y (.a_i(vy_cur), .b_i(dvy), .y_o(vy_d));
    sat_add #(.A_W(POSITION_SIZE), .B_W(VELOCITY_SIZE), .OUT_W(POSITION_SIZE), .SUM_W(SUM_W),
              .CLAMP_EN(1'b0), .CLAMP_MAX(0))
        u_pos_x (.a_i(px_cur), .b_i(dpx), .y_o(px_d));
    sat_add #(.A_W(POSITION_SIZE), .B_W(VELOCITY_SIZE), .OUT_W(POSITION_SIZE), .SUM_W(SUM_W),
              .CLAMP_EN(1'b0), .CLAMP_MAX(0))
        u_pos_y (.a_i(py_cur), .b_i(dpy), .y_o(py_d));

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the node arrays are reset because they drive the outputs directly.
            state_q <= IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            vel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (force_valid_in) err_q <= 1'b1;
                    if (init_valid) begin
                        pos_q <= init_nodes;
                        vel_q <= init_velocities;
                    end
                    if (step_start) begin
                        idx_q   <= '0;
                        state_q <= ACCUM;
                        busy_q  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (force_valid_in) begin
                        vel_q[0][idx_q] <= vx_d;
                        vel_q[1][idx_q] <= vy_d;
                        pos_q[0][idx_q] <= px_d;
                        pos_q[1][idx_q] <= py_d;
                        if (idx_q == IDX_W'(NUM_NODES - 1)) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (force_valid_in) err_q <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nodes_out      = pos_q;
    assign velocities_out = vel_q;
    assign busy_out       = busy_q;
    assign output_valid   = valid_q;
    assign err_out        = err_q;

endmodule
